// File: rtl/pwm_decoder_if.sv
// Signal bundle between a PWM source/consumer and pwm_decoder.
// The decoder takes the slave view; the environment takes the master view.
interface pwm_decoder_if;
   logic       en;
   logic       pwm_in;
   logic [7:0] sample;
   logic       sample_valid;
   logic       locked;
   logic       frame_err;

   modport master (
      output en, pwm_in,
      input  sample, sample_valid, locked, frame_err
   );

   modport slave (
      input  en, pwm_in,
      output sample, sample_valid, locked, frame_err
   );
endinterface

// File: rtl/pwm_decoder.sv
// Recovers an 8-bit amplitude from a 256-clock PWM frame, tracking frame alignment.
// Define PWM_DEC_GLITCH_EN to add a 2-of-3 majority filter that rejects one-cycle pulses.
module pwm_decoder (
   input  logic         clk,
   input  logic         reset,
   pwm_decoder_if.slave bus
);
   typedef enum logic {
      S_SEARCH = 1'b0,
      S_TRACK  = 1'b1
   } state_t;

   logic       r_sync1;
   logic       r_sync2;
   logic       r_pf_d;
   logic       w_pf;
   logic       w_rise;
   logic [8:0] w_acc_sum;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [8:0] r_acc;
   logic [8:0] w_acc_nxt;
   logic [7:0] r_sample;
   logic [7:0] w_sample_nxt;
   logic       r_sample_valid;
   logic       w_sample_valid_nxt;
   logic       r_locked;
   logic       w_locked_nxt;
   logic       r_frame_err;
   logic       w_frame_err_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PWM_DEC_GLITCH_EN
   logic r_ps_d1;
   logic r_pf;

   // Majority over three consecutive synchronised samples, newest still in r_sync1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ps_d1 <= 1'b0;
         r_pf    <= 1'b0;
      end else begin
         r_ps_d1 <= r_sync2;
         r_pf    <= (r_sync1 & r_sync2) | (r_sync1 & r_ps_d1) | (r_sync2 & r_ps_d1);
      end
   end

   assign w_pf = r_pf;
`else
   assign w_pf = r_sync2;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pf_d <= 1'b0;
      else       r_pf_d <= w_pf;
   end

   assign w_rise    = w_pf & ~r_pf_d;
   assign w_acc_sum = r_acc + {8'd0, w_pf};

   // NOTE: every value driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_acc_nxt          = r_acc;
      w_sample_nxt       = r_sample;
      w_sample_valid_nxt = 1'b0;
      w_frame_err_nxt    = 1'b0;
      w_locked_nxt       = r_locked;

      if (!bus.en) begin
         w_state_nxt  = S_SEARCH;
         w_cnt_nxt    = 8'd0;
         w_acc_nxt    = 9'd0;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            S_SEARCH: begin
               w_cnt_nxt = 8'd0;
               w_acc_nxt = 9'd0;
               if (w_rise) begin
                  w_state_nxt = S_TRACK;
                  w_cnt_nxt   = 8'd1;
                  w_acc_nxt   = 9'd1;
               end
            end
            S_TRACK: begin
               // A misaligned rise outranks frame completion, even on the last cycle.
               if (w_rise && (r_cnt != 8'd0)) begin
                  w_frame_err_nxt = 1'b1;
                  w_locked_nxt    = 1'b0;
                  w_cnt_nxt       = 8'd1;
                  w_acc_nxt       = 9'd1;
               end else if (r_cnt == 8'd255) begin
                  w_sample_nxt       = w_acc_sum[8] ? 8'hFF : w_acc_sum[7:0];
                  w_sample_valid_nxt = 1'b1;
                  w_locked_nxt       = 1'b1;
                  w_cnt_nxt          = 8'd0;
                  w_acc_nxt          = 9'd0;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
                  w_acc_nxt = w_acc_sum;
               end
            end
            default: w_state_nxt = S_SEARCH;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_SEARCH;
         r_cnt          <= 8'd0;
         r_acc          <= 9'd0;
         r_sample       <= 8'd0;
         r_sample_valid <= 1'b0;
         r_locked       <= 1'b0;
         r_frame_err    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_acc          <= w_acc_nxt;
         r_sample       <= w_sample_nxt;
         r_sample_valid <= w_sample_valid_nxt;
         r_locked       <= w_locked_nxt;
         r_frame_err    <= w_frame_err_nxt;
      end
   end

   assign bus.sample       = r_sample;
   assign bus.sample_valid = r_sample_valid;
   assign bus.locked       = r_locked;
   assign bus.frame_err    = r_frame_err;
endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: duty table, corner sequences and random frames
// compared every cycle against a frame-level reference model.
module tb_pwm_decoder;
`ifdef PWM_DEC_GLITCH_EN
   localparam bit GLITCH = 1'b1;
`else
   localparam bit GLITCH = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pwm_decoder_if bus ();
   pwm_decoder dut (.clk(clk), .reset(reset), .bus(bus.slave));

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int obs_sv   = 0;
   int obs_fe   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: input history -> filtered level, frames kept as a queue of levels.
   bit       m_hist[4];
   bit       m_pf_prev;
   bit       m_track;
   bit       m_frame_q[$];
   bit       m_locked;
   bit [7:0] m_sample;
   bit       m_sv;
   bit       m_fe;

   function automatic void model_reset();
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      m_pf_prev = 1'b0;
      m_track   = 1'b0;
      m_frame_q.delete();
      m_locked  = 1'b0;
      m_sample  = 8'd0;
      m_sv      = 1'b0;
      m_fe      = 1'b0;
   endfunction

   function automatic void model_step(input bit in_now, input bit en_now);
      bit pf;
      bit rise;
      int ones;
      int sum;
      ones = int'(m_hist[1]) + int'(m_hist[2]) + int'(m_hist[3]);
      pf   = GLITCH ? (ones >= 2) : m_hist[1];
      rise = pf && !m_pf_prev;
      m_pf_prev = pf;
      m_hist[3] = m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = in_now;
      m_sv = 1'b0;
      m_fe = 1'b0;
      if (!en_now) begin
         m_track  = 1'b0;
         m_locked = 1'b0;
         m_frame_q.delete();
      end else if (!m_track) begin
         if (rise) begin
            m_track = 1'b1;
            m_frame_q.delete();
            m_frame_q.push_back(pf);
         end
      end else if (rise && m_frame_q.size() != 0) begin
         m_fe     = 1'b1;
         m_locked = 1'b0;
         m_frame_q.delete();
         m_frame_q.push_back(pf);
      end else begin
         m_frame_q.push_back(pf);
         if (m_frame_q.size() == 256) begin
            sum = 0;
            foreach (m_frame_q[i]) sum += int'(m_frame_q[i]);
            m_sample = (sum > 255) ? 8'd255 : 8'(sum);
            m_sv     = 1'b1;
            m_locked = 1'b1;
            m_frame_q.delete();
         end
      end
   endfunction

   task automatic tick(input bit pwm);
      bus.pwm_in = pwm;
      @(posedge clk);
      if (reset) model_reset();
      else       model_step(pwm, bus.en);
      #1;
      if (bus.sample_valid) obs_sv++;
      if (bus.frame_err)    obs_fe++;
      check($sformatf("cyc%0d", cyc),
            {21'd0, bus.locked, bus.frame_err, bus.sample_valid, bus.sample},
            {21'd0, m_locked, m_fe, m_sv, m_sample});
      cyc++;
   endtask

   // Drives len cycles of a frame of the given duty; optionally checks the
   // previous frame's result a few cycles in, once its strobe has landed.
   task automatic send_frame(input int duty, input int len, input bit do_chk,
                             input string name, input int exp_sample, input bit exp_locked);
      for (int p = 0; p < len; p++) begin
         tick(p < duty);
         if (do_chk && p == 5) begin
            check({name, "_sample"}, {24'd0, bus.sample}, exp_sample);
            check({name, "_locked"}, {31'd0, bus.locked}, {31'd0, exp_locked});
         end
      end
   endtask

   typedef struct {
      int duty;
      int frames;
      int exp_sample;
   } vec_t;

   vec_t vecs[9];
   int   prev_exp;
   bit   prev_ok;
   int   fe0;
   int   sv0;

   initial begin
      vecs[0] = '{duty: 128, frames: 5, exp_sample: 128};
      vecs[1] = '{duty: 64,  frames: 2, exp_sample: 64};
      vecs[2] = '{duty: 0,   frames: 3, exp_sample: 0};
      vecs[3] = '{duty: 256, frames: 2, exp_sample: 255};
      vecs[4] = '{duty: 1,   frames: 2, exp_sample: 1};
      vecs[5] = '{duty: 255, frames: 2, exp_sample: 255};
      vecs[6] = '{duty: 100, frames: 2, exp_sample: 100};
      vecs[7] = '{duty: 37,  frames: 1, exp_sample: 37};
      vecs[8] = '{duty: 0,   frames: 2, exp_sample: 0};

      reset      = 1'b1;
      bus.en     = 1'b0;
      bus.pwm_in = 1'b0;
      model_reset();
      repeat (3) tick(1'b1);
      check("rst_outputs", {21'd0, bus.locked, bus.frame_err, bus.sample_valid, bus.sample}, 32'd0);
      reset  = 1'b0;
      bus.en = 1'b1;
      repeat (10) tick(1'b0);
      check("idle_nostrobe", obs_sv, 0);

      // Table: every frame after the first checks the one before it.
      prev_ok  = 1'b0;
      prev_exp = 0;
      for (int i = 0; i < 9; i++) begin
         for (int f = 0; f < vecs[i].frames; f++) begin
            send_frame(vecs[i].duty, 256, prev_ok, $sformatf("vec%0d", i), prev_exp, 1'b1);
            prev_ok  = 1'b1;
            prev_exp = vecs[i].exp_sample;
         end
      end
      check("table_no_fe", obs_fe, 0);

      // Single-cycle high glitch inside a duty-0 frame.
      fe0 = obs_fe;
      for (int p = 0; p < 256; p++) tick(p == 50);
      send_frame(0, 256, 1'b0, "g1", 0, 1'b1);
      send_frame(0, 256, 1'b1, "glitch", GLITCH ? 0 : 1, 1'b1);
      check("glitch_fe", obs_fe - fe0, GLITCH ? 0 : 1);

      // Early frame start, 37 clocks short.
      send_frame(100, 256, 1'b0, "sync", 0, 1'b0);
      send_frame(100, 256, 1'b0, "sync", 0, 1'b0);
      send_frame(100, 256, 1'b1, "d100", 100, 1'b1);
      send_frame(100, 219, 1'b0, "short", 0, 1'b0);
      fe0 = obs_fe;
      sv0 = obs_sv;
      send_frame(100, 256, 1'b1, "early", 100, 1'b0);
      check("early_fe", obs_fe - fe0, 1);
      check("early_nosv", obs_sv - sv0, 0);
      send_frame(100, 256, 1'b1, "relock", 100, 1'b1);

      // Reset asserted at frame cycle 120.
      send_frame(128, 256, 1'b1, "pre128", 100, 1'b1);
      send_frame(128, 120, 1'b1, "mid128", 128, 1'b1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_async", {21'd0, bus.locked, bus.frame_err, bus.sample_valid, bus.sample}, 32'd0);
      repeat (3) tick(1'b0);
      reset = 1'b0;
      sv0 = obs_sv;
      repeat (300) tick(1'b0);
      check("rst_nosv", obs_sv - sv0, 0);
      send_frame(128, 256, 1'b0, "rs", 0, 1'b0);
      send_frame(128, 256, 1'b1, "post_rst", 128, 1'b1);

      // Random frames, early restarts, enable drops and glitches.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: send_frame(int'($urandom_range(0, 256)), 256, 1'b0, "rnd", 0, 1'b0);
            1: send_frame(int'($urandom_range(0, 256)), int'($urandom_range(1, 255)), 1'b0, "rnd", 0, 1'b0);
            2: begin
               bus.en = 1'b0;
               repeat ($urandom_range(1, 20)) tick(1'($urandom));
               bus.en = 1'b1;
            end
            default: begin
               int gp;
               gp = int'($urandom_range(1, 254));
               for (int p = 0; p < 256; p++) tick(p == gp);
            end
         endcase
      end
      send_frame(77, 256, 1'b0, "tail", 0, 1'b0);
      send_frame(77, 256, 1'b0, "tail", 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The block SHALL have a single clock domain and SHALL use an asynchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge system clock.
REQ-003 Port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `en`: input, 1 bit, decoder enable.
REQ-005 Port `pwm_in`: input, 1 bit, asynchronous PWM stream with a 256-clock frame.
REQ-006 Port `sample`: output, 8 bits, recovered amplitude equal to the count of high cycles in the last frame.
REQ-007 Port `sample_valid`: output, 1 bit, one-cycle strobe marking a new `sample`.
REQ-008 Port `locked`: output, 1 bit, frame alignment established.
REQ-009 Port `frame_err`: output, 1 bit, one-cycle strobe on a misaligned rising edge.

Function
REQ-010 `pwm_in` SHALL pass through a 2-flop synchronizer to give `p_s`; the filtered level `p_f` SHALL equal `p_s` unless REQ-031 applies.
REQ-011 A rise SHALL be `p_f`=1 with the registered previous `p_f`=0.
REQ-012 The FSM SHALL have two states: SEARCH and TRACK.
REQ-013 In SEARCH, the 8-bit frame counter `cnt` and the 9-bit accumulator `acc` SHALL be held at 0.
REQ-014 In SEARCH, a rise SHALL move the FSM to TRACK; that cycle SHALL be frame cycle 0 (`cnt`<=1, `acc`<=1).
REQ-015 In TRACK, each cycle `cnt` SHALL increment modulo 256 and `acc` SHALL add `p_f`.
REQ-016 At frame cycle 255, `sample` SHALL register min(`acc` including cycle 255, 255), i.e. a 256-high frame saturates to 255.
REQ-017 `sample_valid` SHALL pulse high for exactly the following cycle.
REQ-018 At frame cycle 255, `acc` SHALL restart at the next cycle's `p_f` value (contiguous frames, no gap cycle).
REQ-019 A rise in TRACK with `cnt`==0 SHALL be the expected alignment and SHALL cause no action.
REQ-020 A rise in TRACK with `cnt`!=0 SHALL:
- pulse `frame_err` for one cycle;
- discard the partial frame (no `sample_valid`);
- clear `locked`;
- restart the frame with that cycle as cycle 0.
REQ-021 `locked` SHALL assert together with the first `sample_valid` after entry to TRACK or after a `frame_err`, and SHALL remain set while frames complete cleanly.
REQ-022 A frame with no rise, i.e. constant level (`acc`=0 gives 0; `acc`=256 gives 255), SHALL be a valid frame and SHALL produce a sample.
REQ-023 `en`=0 SHALL force SEARCH, clear `locked`, `cnt` and `acc`, and suppress strobes; `sample` SHALL hold its last value.
REQ-024 If frame cycle 255 and a misaligned rise coincide, the rise SHALL win: a `frame_err` pulse and no `sample_valid`.
REQ-025 Latency from a `pwm_in` edge to `p_f` SHALL be 2 clocks (3 with REQ-031).
REQ-026 `sample_valid` SHALL follow the last frame cycle by 1 clock.

Reset
REQ-027 While `reset` is high, the FSM SHALL be in SEARCH and `sample`=0, `sample_valid`=0, `locked`=0, `frame_err`=0.
REQ-028 While `reset` is high, `cnt`, `acc`, the synchronizer and filter flops SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-030 After reset release, a new rise SHALL be required before decoding resumes.

Configuration
REQ-031 With macro PWM_DEC_GLITCH_EN defined, `p_f` SHALL be the registered 2-of-3 majority of the last three `p_s` values, rejecting single-cycle pulses at +1 cycle latency.
REQ-032 With PWM_DEC_GLITCH_EN undefined, `p_f`=`p_s` and no filter logic SHALL exist.

Verification
REQ-033 Reset then 5 frames at duty 128/256 -> `sample_valid` every 256 clocks with `sample`=128, `locked`=1 from the first strobe, `frame_err` never asserted.
REQ-034 Locked at duty 64, then `pwm_in` held low for 3 frames -> `sample`=64, then 0, 0, 0; `locked` stays 1.
REQ-035 Locked, then `pwm_in` held high -> `sample` sequence ends at 255 (saturated), no `frame_err`.
REQ-036 Locked at duty 100, then a frame is started 37 clocks early -> one `frame_err` pulse, no `sample_valid` for the broken frame, `locked`=0, then `sample`=100 with `locked`=1 256 clocks later.
REQ-037 `reset` pulsed at frame cycle 120 -> outputs 0 immediately; no strobe until a rise plus 256 clocks.
REQ-038 With PWM_DEC_GLITCH_EN, a single-cycle high glitch inside a duty-0 frame -> `sample`=0, no `frame_err`; without the macro, the same stimulus -> `frame_err` pulse.
